// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-point majority sampling, parity/framing/break
// status per word, and a valid/ready output register with an overrun pulse.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 2_500_000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BPS_CNT = CLK_FREQ / BAUD;
    localparam int unsigned HALF    = BPS_CNT / 2;
    localparam int unsigned CNT_W   = $clog2(BPS_CNT);
    localparam logic        ODD_PAR = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    logic [1:0]           sync_q;
    logic                 hist_q;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic line_c, start_edge_c, tick_c, wrap_c, bit_val_c, done_c;

    assign line_c       = sync_q[1];
    assign start_edge_c = hist_q & ~line_c;
    assign tick_c       = (clk_cnt_q == CNT_W'(HALF + 1));
    assign wrap_c       = (clk_cnt_q == CNT_W'(BPS_CNT - 1));
    assign bit_val_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & line_c) | (smp_q[1] & line_c);

    // Synchroniser and edge-history flops; idle-high so reset never fakes a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
            hist_q <= sync_q[1];
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state: bit timing, majority sampling and per-state bit handling
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        par_d     = par_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done_c    = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = wrap_c ? '0 : clk_cnt_q + CNT_W'(1);
            if (clk_cnt_q == CNT_W'(HALF - 1)) smp_d[0] = line_c;
            if (clk_cnt_q == CNT_W'(HALF))     smp_d[1] = line_c;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_edge_c) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    par_d     = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick_c && bit_val_c) begin
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                end else if (wrap_c) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (bit_cnt_q == 4'(i)) shift_d[i] = bit_val_c;
                    end
                end
                if (wrap_c) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (tick_c) begin
                    par_d  = bit_val_c;
                    perr_d = ((^shift_q) ^ bit_val_c) != ODD_PAR;
                end
                if (wrap_c) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    if (!bit_val_c) ferr_d = 1'b1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        done_c    = 1'b1;
                        state_d   = S_IDLE;
                        clk_cnt_d = '0;
                    end
                end else if (wrap_c) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register next-state: load, drop with overrun, or handshake clear
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_d      = brk_q;
        ovr_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);

        if (done_c) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                perr_out_d = perr_q;
                ferr_out_d = ferr_d;
                brk_d      = ferr_d & ~(|shift_q) & ~par_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the control-board serial link, replacing the fixed 8N1 receiver. Clock frequency, baud rate, data width, parity mode and stop-bit count are set at elaboration. Each bit is sampled by 3-point majority vote, and each received word is reported with parity, framing, break and overrun status. Received words leave through a valid/ready handshake toward the command decoder.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz
- BAUD, 2_500_000, line rate in bit/s; BPS_CNT = CLK_FREQ/BAUD (truncating), must be ≥ 8
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame, 1 or 2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rxd  in  1  serial input, asynchronous, idles high
- rx_data  out  DATA_BITS  received word, LSB first on the line
- rx_valid  out  1  rx_data and status flags are valid
- rx_ready  in  1  consumer accepts the word
- parity_err  out  1  parity mismatch, qualified by rx_valid
- frame_err  out  1  a stop bit was sampled low, qualified by rx_valid
- break_det  out  1  frame_err with all data bits 0 and parity bit 0, qualified by rx_valid
- overrun  out  1  one-cycle pulse when a completed word is dropped
- busy  out  1  high while the FSM is not in IDLE

## Operation
- Input path:
  - uart_rxd passes through a 2-flop synchroniser (reset value 1) and then a history flop (reset value 1).
  - A start is the falling edge of the synchronised line: history = 1, current = 0.
- The FSM has five states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START on a start edge. clk_cnt clears to 0 and bit_cnt clears to 0.
  - clk_cnt runs 0..BPS_CNT-1 in every bit, then wraps to 0 and advances to the next bit.
  - HALF = BPS_CNT/2.
  - The bit value is the majority of the synchronised samples taken at clk_cnt = HALF-1, HALF and HALF+1. The decision is made at clk_cnt = HALF+1.
- START: a majority value of 1 is a false start → return to IDLE; no output and no flags. Otherwise, at the wrap, go to DATA.
- DATA: the decided bit shifts into bit position bit_cnt, LSB first. After DATA_BITS bits: go to PAR if PARITY ≠ 0, else to STOP.
- PAR: compare the decided bit with the expected parity.
  - Odd parity: XOR of data bits XOR parity bit must be 1.
  - Even parity: XOR of data bits XOR parity bit must be 0.
  - A mismatch sets internal perr.
- STOP: each stop bit is decided at HALF+1; a value of 0 sets internal ferr.
  - After the last stop-bit decision, the FSM enters IDLE immediately, without waiting for the bit end. This allows resynchronisation on the next start edge.
  - That same cycle is the completion event.
- Output register, on a completion event:
  - If rx_valid = 0, or rx_valid = 1 with rx_ready = 1 in the same cycle: load rx_data, parity_err, frame_err and break_det, and set rx_valid = 1. No overrun.
  - If rx_valid = 1 and rx_ready = 0: the new word is discarded, the old word and flags are held, and overrun pulses for 1 cycle.
- rx_valid clears on rx_valid && rx_ready when no completion occurs in that cycle.
- Reset, including mid-frame: all state is cleared and the FSM enters IDLE.
  - Output reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, break_det = 0, overrun = 0, busy = 0.
  - The partial frame is lost. The synchroniser resets high, so releasing reset while the line is low produces no spurious start.
- Width rule: bit_cnt is 4 bits. clk_cnt is $clog2(BPS_CNT) bits.

## Timing
- Start detection occurs 3 clk after the line falls (2 synchroniser stages plus the history flop).
- Completion occurs at clk_cnt = HALF+1 of the last stop bit. rx_valid rises on the next clk edge.
- With 8N1 and BPS_CNT = 40, rx_valid rises 3 + 9·40 + 21 + 1 = 385 clk after the start falling edge.
- Flags change only when rx_valid is loaded, and are stable while rx_valid = 1.
- Back-to-back frames with no idle gap are received without loss, provided each word is accepted before the next completion.
- busy rises 1 clk after start detection and falls in the cycle after completion or false-start rejection.

## Test plan
- 8N1, BPS_CNT = 40, send 0xA5 with rx_ready held at 1 → rx_valid high for 1 cycle, 385 clk after the edge; rx_data = 0xA5; all flags 0.
- PARITY = 2, send 0x37 with parity bit 0 (the correct bit is 1) → rx_data = 0x37, parity_err = 1. Resend with parity bit 1 → parity_err = 0.
- Send 0x00 with the stop bit low → frame_err = 1 and break_det = 1. Send 0x01 with the stop bit low → frame_err = 1 and break_det = 0.
- Drive uart_rxd low for 15 clk, then high → busy pulses, returns to 0; rx_valid never rises. Inject a 1-clk low glitch at the mid-sample of a data-bit-1 → data received unchanged.
- Hold rx_ready = 0 and send 0x11 then 0x22 → rx_data stays 0x11, and overrun pulses 1 cycle at the second completion. Raise rx_ready → rx_valid falls on the next clk.
- Assert rst_n = 0 during data bit 4 of a frame → all outputs return to reset values and no word is output. After release, send 0x5A → received correctly.
